fpu_compare_unit: RTL and testbench

FPU_COMPARE_UNIT -- requirements
Module: fpu_compare_unit

---
 rtl/fpu_cmp_pkg.sv | 23 ++
 rtl/fpu_cmp_core.sv | 75 +++++++
 rtl/fpu_compare_unit.sv | 108 ++++++++++
 tb/tb_fpu_compare_unit.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_cmp_pkg.sv
// Shared definitions for the compare unit: operation encodings and the result flag bundle.
package fpu_cmp_pkg;

    typedef enum logic [1:0] {
        MODE_UABS = 2'b00,
        MODE_SSUB = 2'b01,
        MODE_FCMP = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef struct packed {
        logic mode_err;
        logic unordered;
        logic gt;
        logic eq;
        logic lt;
        logic overflow;
        logic sign;
    } flags_t;

    localparam int FLAG_W = $bits(flags_t);

endpackage

// File: rtl/fpu_cmp_core.sv
// Combinational compare/subtract datapath: unsigned |a-b|, signed a-b, IEEE-style float compare.
module fpu_cmp_core
    import fpu_cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int EXP_W = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] difference,
    output flags_t           flags
);
    localparam int FRAC_W = WIDTH - 1 - EXP_W;

    mode_e            op;
    logic [WIDTH-1:0] sub_ab;
    logic [WIDTH-1:0] sub_ba;
    logic             u_lt, u_eq, s_lt, s_ovf;
    logic             a_nan, b_nan, both_zero;
    logic             mag_lt, mag_eq, f_eq, f_lt;

    assign op     = mode_e'(mode);
    assign sub_ab = a - b;
    assign sub_ba = b - a;
    assign u_lt   = a < b;
    assign u_eq   = a == b;
    assign s_lt   = $signed(a) < $signed(b);
    assign s_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ab[WIDTH-1] != a[WIDTH-1]);

    assign a_nan     = (&a[WIDTH-2 -: EXP_W]) && (|a[FRAC_W-1:0]);
    assign b_nan     = (&b[WIDTH-2 -: EXP_W]) && (|b[FRAC_W-1:0]);
    assign both_zero = ~|{a[WIDTH-2:0], b[WIDTH-2:0]};
    assign mag_lt    = a[WIDTH-2:0] < b[WIDTH-2:0];
    assign mag_eq    = a[WIDTH-2:0] == b[WIDTH-2:0];

    // Sign-magnitude order: opposite signs decide directly, negatives reverse the magnitude order.
    assign f_eq = both_zero || u_eq;
    assign f_lt = !f_eq && ((a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1]
                          : (a[WIDTH-1] ? (!mag_lt && !mag_eq) : mag_lt));

    always_comb begin
        flags      = '0;
        difference = u_lt ? sub_ba : sub_ab;
        case (op)
            MODE_SSUB: begin
                difference     = sub_ab;
                flags.lt       = s_lt;
                flags.eq       = u_eq;
                flags.gt       = !s_lt && !u_eq;
                flags.sign     = s_lt;
                flags.overflow = s_ovf;
            end
            MODE_FCMP: begin
                difference = '0;
                if (a_nan || b_nan) begin
                    flags.unordered = 1'b1;
                end else begin
                    flags.lt   = f_lt;
                    flags.eq   = f_eq;
                    flags.gt   = !f_lt && !f_eq;
                    flags.sign = f_lt;
                end
            end
            default: begin
                flags.lt       = u_lt;
                flags.eq       = u_eq;
                flags.gt       = !u_lt && !u_eq;
                flags.sign     = u_lt;
                flags.mode_err = (op == MODE_RSVD);
            end
        endcase
    end

endmodule

// File: rtl/fpu_compare_unit.sv
// Two-stage valid/ready compare unit: S1 holds operands, S2 holds results; counts unordered results.
module fpu_compare_unit
    import fpu_cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int EXP_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] difference,
    output logic             sign,
    output logic             overflow,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic             unordered,
    output logic             mode_err,
    output logic [CNT_W-1:0] nan_cnt
);
    logic             s1_valid_reg, s2_valid_reg;
    logic [WIDTH-1:0] s1_a_reg, s1_b_reg;
    logic [1:0]       s1_mode_reg;
    logic [WIDTH-1:0] s2_diff_reg;
    flags_t           s2_flags_reg;
    logic [CNT_W-1:0] nan_cnt_reg, nan_cnt_next;

    logic             s1_adv, s2_adv, out_xfer;
    logic [WIDTH-1:0] core_diff;
    flags_t           core_flags;
    logic [FLAG_W-1:0] flag_bits, flag_gated;
    flags_t           out_flags;

    assign s2_adv   = !s2_valid_reg || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_adv;
    assign in_ready = s1_adv && rst_n;
    assign out_xfer = s2_valid_reg && out_ready;

    fpu_cmp_core #(.WIDTH(WIDTH), .EXP_W(EXP_W)) u_core (
        .a          (s1_a_reg),
        .b          (s1_b_reg),
        .mode       (s1_mode_reg),
        .difference (core_diff),
        .flags      (core_flags)
    );

    always_comb begin
        nan_cnt_next = nan_cnt_reg;
        if (out_xfer && s2_flags_reg.unordered && (nan_cnt_reg != {CNT_W{1'b1}}))
            nan_cnt_next = nan_cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            nan_cnt_reg  <= '0;
        end else begin
            nan_cnt_reg <= nan_cnt_next;
            if (flush) begin
                s1_valid_reg <= 1'b0;
                s2_valid_reg <= 1'b0;
            end else begin
                if (s1_adv) s1_valid_reg <= in_valid;
                if (s2_adv) s2_valid_reg <= s1_valid_reg;
            end
        end
    end

    // Data registers carry no reset; their contents are only observable behind the valid bits.
    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_a_reg    <= a;
            s1_b_reg    <= b;
            s1_mode_reg <= mode;
        end
        if (s2_adv) begin
            s2_diff_reg  <= core_diff;
            s2_flags_reg <= core_flags;
        end
    end

    assign flag_bits = s2_flags_reg;
    for (genvar gi = 0; gi < FLAG_W; gi++) begin : g_flag_gate
        assign flag_gated[gi] = flag_bits[gi] & s2_valid_reg;
    end
    assign out_flags = flags_t'(flag_gated);

    assign out_valid  = s2_valid_reg;
    assign difference = s2_diff_reg;
    assign sign       = out_flags.sign;
    assign overflow   = out_flags.overflow;
    assign lt         = out_flags.lt;
    assign eq         = out_flags.eq;
    assign gt         = out_flags.gt;
    assign unordered  = out_flags.unordered;
    assign mode_err   = out_flags.mode_err;
    assign nan_cnt    = nan_cnt_reg;

endmodule

// File: tb/tb_fpu_compare_unit.sv
// Self-checking bench for fpu_compare_unit: directed scenarios plus a randomized scoreboard run.
module tb_fpu_compare_unit;
    localparam int WIDTH = 32;
    localparam int EXP_W = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [1:0]       mode = 2'b00;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] difference;
    logic             sign, overflow, lt, eq, gt, unordered, mode_err;
    logic [CNT_W-1:0] nan_cnt;
    logic [6:0]       fl;

    int checks = 0;
    int failures = 0;

    fpu_compare_unit #(.WIDTH(WIDTH), .EXP_W(EXP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .difference(difference),
        .sign(sign), .overflow(overflow), .lt(lt), .eq(eq), .gt(gt),
        .unordered(unordered), .mode_err(mode_err),
        .nan_cnt(nan_cnt)
    );

    always #5 clk = ~clk;

    assign fl = {mode_err, unordered, gt, eq, lt, overflow, sign};

    // Reference: returns {difference, mode_err, unordered, gt, eq, lt, overflow, sign}
    function automatic logic [38:0] model(input logic [31:0] x, input logic [31:0] y, input logic [1:0] m);
        longint ux, uy, sx, sy, dv, kx, ky;
        logic [31:0] d;
        logic me, un, g, e, l, ov, s;
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        me = 0; un = 0; g = 0; e = 0; l = 0; ov = 0; s = 0;
        d = '0;
        if (m == 2'b01) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            dv = sx - sy;
            d  = 32'(dv);
            ov = (dv > 64'sd2147483647) || (dv < -64'sd2147483648);
            l = sx < sy; e = sx == sy; g = sx > sy; s = l;
        end else if (m == 2'b10) begin
            if ((x[30:23] == 8'hFF && x[22:0] != 0) || (y[30:23] == 8'hFF && y[22:0] != 0)) begin
                un = 1;
            end else begin
                kx = longint'({33'b0, x[30:0]});
                ky = longint'({33'b0, y[30:0]});
                if (x[31]) kx = -kx;
                if (y[31]) ky = -ky;
                l = kx < ky; e = kx == ky; g = kx > ky; s = l;
            end
        end else begin
            d = 32'((ux > uy) ? (ux - uy) : (uy - ux));
            l = ux < uy; e = ux == uy; g = ux > uy; s = l;
            me = (m == 2'b11);
        end
        return {d, me, un, g, e, l, ov, s};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h7F80_0000;
            3: return 32'hFF80_0000;
            4: return 32'h7FC0_0000 | 32'($urandom_range(0, 255));
            5: return 32'hFF80_0001;
            default: return $urandom;
        endcase
    endfunction

    // Single transaction with out_ready=1; returns at the negedge where the result is first visible.
    task automatic send_one(input logic [31:0] ta, input logic [31:0] tb_v, input logic [1:0] tm,
                            output logic [31:0] d, output logic [6:0] f, output int lat);
        @(negedge clk);
        a = ta; b = tb_v; mode = tm; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        d = difference;
        f = fl;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || nan_cnt !== '0) begin
            failures++;
            $display("FAIL reset_state got in_ready=%b out_valid=%b nan_cnt=%0d exp 0/0/0", in_ready, out_valid, nan_cnt);
        end
        checks++;
        if (fl !== 7'd0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000000", fl);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_uabs();
        logic [31:0] d; logic [6:0] f; int lat;
        send_one(32'd5, 32'd9, 2'b00, d, f, lat);
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL uabs_latency got=%0d exp=2", lat);
        end
        checks++;
        if ({d, f} !== {32'd4, 7'b0000101}) begin
            failures++;
            $display("FAIL uabs_result got=%h/%b exp=%h/%b", d, f, 32'd4, 7'b0000101);
        end
    endtask

    task automatic test_ssub();
        logic [31:0] d; logic [6:0] f; int lat;
        send_one(32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'b01, d, f, lat);
        checks++;
        if ({d, f} !== {32'h8000_0000, 7'b0010010}) begin
            failures++;
            $display("FAIL ssub_overflow got=%h/%b exp=%h/%b", d, f, 32'h8000_0000, 7'b0010010);
        end
    endtask

    task automatic test_fcmp();
        logic [31:0] d; logic [6:0] f; int lat;
        send_one(32'h0000_0000, 32'h8000_0000, 2'b10, d, f, lat);
        checks++;
        if ({d, f} !== {32'd0, 7'b0001000}) begin
            failures++;
            $display("FAIL fcmp_zero_eq got=%h/%b exp=%h/%b", d, f, 32'd0, 7'b0001000);
        end
        send_one(32'h7FC0_0000, 32'h3F80_0000, 2'b10, d, f, lat);
        checks++;
        if (f !== 7'b0100000) begin
            failures++;
            $display("FAIL fcmp_nan_flags got=%b exp=0100000", f);
        end
        checks++;
        if (nan_cnt !== 16'd0) begin
            failures++;
            $display("FAIL nan_cnt_before got=%0d exp=0", nan_cnt);
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (nan_cnt !== 16'd1) begin
            failures++;
            $display("FAIL nan_cnt_after got=%0d exp=1", nan_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] av[4];
        logic [38:0] held;
        bit hold_pend;
        int sent, got, cyc;
        av = '{32'd10, 32'd20, 32'd30, 32'd40};
        sent = 0; got = 0; cyc = 0; hold_pend = 0; held = '0;
        while (got < 4 && cyc < 30) begin
            @(negedge clk);
            out_ready = (cyc >= 3);
            in_valid = (sent < 4);
            if (sent < 4) begin
                a = av[sent]; b = 32'd3; mode = 2'b00;
            end
            #1;
            if (cyc == 2) begin
                checks++;
                if (sent !== 2 || in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_in_ready_drop got accepts=%0d in_ready=%b exp 2/0", sent, in_ready);
                end
            end
            if (hold_pend) begin
                checks++;
                if ({difference, fl} !== held || out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_hold got=%h exp=%h", {difference, fl}, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if ({difference, fl} !== model(av[got], 32'd3, 2'b00)) begin
                    failures++;
                    $display("FAIL bp_order idx=%0d got=%h exp=%h", got, {difference, fl}, model(av[got], 32'd3, 2'b00));
                end
                got++;
            end
            hold_pend = out_valid && !out_ready;
            held = {difference, fl};
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got !== 4) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=4", got);
        end
    endtask

    task automatic test_reset_midflight();
        bit seen;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; a = 32'd1; b = 32'd2; mode = 2'b00;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || nan_cnt !== '0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got out_valid=%b nan_cnt=%0d in_ready=%b exp 0/0/0", out_valid, nan_cnt, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_discard got out_valid seen=%b exp=0", seen);
        end
    endtask

    task automatic test_flush_mode_err();
        logic [31:0] d; logic [6:0] f; int lat;
        bit seen;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; a = 32'h7FC0_0001; b = 32'd0; mode = 2'b10;
        @(negedge clk);
        flush = 1'b1; a = 32'd7; b = 32'd1; mode = 2'b00;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL flush_drop got out_valid seen=%b exp=0", seen);
        end
        checks++;
        if (nan_cnt !== 16'd0) begin
            failures++;
            $display("FAIL flush_nan_cnt got=%0d exp=0", nan_cnt);
        end
        send_one(32'd3, 32'd10, 2'b11, d, f, lat);
        checks++;
        if ({d, f} !== {32'd7, 7'b1000101}) begin
            failures++;
            $display("FAIL mode_err_result got=%h/%b exp=%h/%b", d, f, 32'd7, 7'b1000101);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [38:0] q[$];
        logic [38:0] held, expv;
        bit hold_pend;
        int exp_cnt;
        hold_pend = 0; held = '0; exp_cnt = 0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            @(negedge clk);
            checks++;
            if (nan_cnt !== 16'(exp_cnt)) begin
                failures++;
                $display("FAIL rnd_nan_cnt cyc=%0d got=%0d exp=%0d", cyc, nan_cnt, exp_cnt);
            end
            if (cyc < 650) begin
                in_valid = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                in_valid = 1'b0;
                out_ready = 1'b1;
            end
            mode = 2'($urandom_range(0, 3));
            a = (mode == 2'b10) ? pick() : $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : ((mode == 2'b10) ? pick() : $urandom);
            #1;
            if (hold_pend) begin
                checks++;
                if ({difference, fl} !== held || out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL rnd_hold cyc=%0d got=%h exp=%h", cyc, {difference, fl}, held);
                end
            end
            if (!out_valid) begin
                checks++;
                if (fl !== 7'd0) begin
                    failures++;
                    $display("FAIL rnd_idle_flags cyc=%0d got=%b exp=0000000", cyc, fl);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_extra cyc=%0d got=%h exp=none", cyc, {difference, fl});
                end else begin
                    expv = q.pop_front();
                    if ({difference, fl} !== expv) begin
                        failures++;
                        $display("FAIL rnd_result cyc=%0d got=%h exp=%h", cyc, {difference, fl}, expv);
                    end
                    if (expv[5] && exp_cnt < 65535) exp_cnt++;
                end
            end
            hold_pend = out_valid && !out_ready;
            held = {difference, fl};
            if (in_valid && in_ready) q.push_back(model(a, b, mode));
        end
        in_valid = 1'b0;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL rnd_drain got pending=%0d exp=0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_uabs();
        test_ssub();
        test_fcmp();
        test_backpressure();
        test_reset_midflight();
        test_flush_mode_err();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
